// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32I memory-access stage: classify, lane-align, request/ack, load extract
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic [31:0] mem_o,
    output logic        done_o,
    output logic        busy_o,
    output logic [1:0]  fault_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_F3    = 2'b10;
    localparam logic [1:0] FAULT_TMO   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t      state, state_next;

    logic        is_load_q, is_store_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [7:0]  cnt;
    logic [1:0]  fault_q;
    logic [31:0] mem_q;

    logic        in_load, in_store, in_f3_legal, in_aligned, in_go_req;
    logic [1:0]  in_fault;
    logic        accept, timeout_hit;
    logic [31:0] load_value;
    logic [31:0] rdata_sh;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    // Only the opcode and funct3 fields of the instruction matter here.
    logic unused_ir;
    assign unused_ir = ^{ir_i[31:15], ir_i[11:7]};

    assign accept      = (state == S_IDLE) && start_i;
    assign timeout_hit = (cnt == CNT_LAST);

    // Classify the incoming instruction: legality of funct3 and address alignment.
    always_comb begin
        in_load     = (ir_i[6:0] == OP_LOAD);
        in_store    = (ir_i[6:0] == OP_STORE);
        in_f3_legal = 1'b0;
        in_aligned  = 1'b0;
        in_fault    = FAULT_NONE;
        if (in_load) begin
            in_f3_legal = (ir_i[14:12] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else if (in_store) begin
            in_f3_legal = (ir_i[14:12] inside {3'b000, 3'b001, 3'b010});
        end
        case (ir_i[13:12])
            2'b00:   in_aligned = 1'b1;
            2'b01:   in_aligned = ~addr_i[0];
            2'b10:   in_aligned = (addr_i[1:0] == 2'b00);
            default: in_aligned = 1'b0;
        endcase
        if (in_load || in_store) begin
            if (!in_f3_legal) begin
                in_fault = FAULT_F3;
            end else if (!in_aligned) begin
                in_fault = FAULT_ALIGN;
            end
        end
        in_go_req = (in_load || in_store) && in_f3_legal && in_aligned;
    end

    // Next-state logic for the IDLE -> (REQ) -> DONE -> IDLE sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_next = in_go_req ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (dmem_ack_i || timeout_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the instruction context at start so execute may move on.
    always_ff @(posedge clk) begin
        if (!reset) begin
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= 32'h0;
            sdata_q    <= 32'h0;
        end else if (accept) begin
            is_load_q  <= in_load;
            is_store_q <= in_store;
            f3_q       <= ir_i[14:12];
            addr_q     <= addr_i;
            sdata_q    <= store_data_i;
        end
    end

    // Wait-cycle counter: cleared at start, counts each cycle spent in REQ.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= 8'h0;
        end else if (accept) begin
            cnt <= 8'h0;
        end else if (state == S_REQ) begin
            cnt <= cnt + 8'h1;
        end
    end

    // Fault status: set at every start, overridden by a timeout; ack beats timeout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_q <= FAULT_NONE;
        end else if (accept) begin
            fault_q <= in_fault;
        end else if (state == S_REQ && !dmem_ack_i && timeout_hit) begin
            fault_q <= FAULT_TMO;
        end
    end

    // Load result register: only a completed load updates it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= 32'h0;
        end else if (state == S_REQ && dmem_ack_i && is_load_q) begin
            mem_q <= load_value;
        end
    end

    // Byte-lane placement of store data and byte enables.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = 32'h0;
        if (is_store_q) begin
            case (f3_q[1:0])
                2'b00: begin
                    lane_be    = 4'b0001 << addr_q[1:0];
                    lane_wdata = {4{sdata_q[7:0]}};
                end
                2'b01: begin
                    lane_be    = 4'b0011 << addr_q[1:0];
                    lane_wdata = {2{sdata_q[15:0]}};
                end
                default: begin
                    lane_be    = 4'b1111;
                    lane_wdata = sdata_q;
                end
            endcase
        end
    end

    // Shift the addressed bytes down to bit 0 and extend per funct3.
    always_comb begin
        rdata_sh = dmem_rdata_i >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_value = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b100:  load_value = {24'h0, rdata_sh[7:0]};
            3'b001:  load_value = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b101:  load_value = {16'h0, rdata_sh[15:0]};
            default: load_value = dmem_rdata_i;
        endcase
    end

    // Memory-side outputs are driven only while a request is outstanding.
    always_comb begin
        dmem_req_o   = (state == S_REQ);
        dmem_we_o    = dmem_req_o && is_store_q;
        dmem_addr_o  = dmem_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
        dmem_be_o    = dmem_req_o ? lane_be : 4'b0000;
        dmem_wdata_o = dmem_req_o ? lane_wdata : 32'h0;
        done_o       = (state == S_DONE);
        busy_o       = (state != S_IDLE);
        mem_o        = mem_q;
        fault_o      = fault_q;
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - table-driven and randomized checks of mem_access
module tb_mem_access;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] ir_i = 32'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] store_data_i = 32'h0;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i = 32'h0;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] mem_o;
    logic        done_o;
    logic        busy_o;
    logic [1:0]  fault_o;

    int total = 0;
    int bad = 0;
    logic [31:0] model_mem = 32'h0;

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .ir_i(ir_i), .addr_i(addr_i),
        .store_data_i(store_data_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i), .mem_o(mem_o),
        .done_o(done_o), .busy_o(busy_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rd;
        int          delay;    // wait cycles before ack; 255 = never ack
        bit          poke;     // pulse start_i again while in REQ
        int          e_done;   // cycle (after start edge) in which done_o is high
        bit          e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [1:0]  e_fault;
        logic [31:0] e_mem;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v);
        int          done_cyc;
        bit          req_seen;
        bit          stable;
        logic [31:0] r_addr, r_wdata;
        logic [3:0]  r_be;
        logic        r_we;
        done_cyc = -1; req_seen = 0; stable = 1;
        r_addr = 0; r_wdata = 0; r_be = 0; r_we = 0;
        @(posedge clk); #1;
        ir_i = v.ir; addr_i = v.addr; store_data_i = v.sd; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; ir_i = ~v.ir; addr_i = ~v.addr; store_data_i = ~v.sd;
        for (int c = 1; c <= 20; c++) begin
            if (dmem_req_o) begin
                if (!req_seen) begin
                    req_seen = 1; r_addr = dmem_addr_o; r_be = dmem_be_o;
                    r_wdata = dmem_wdata_o; r_we = dmem_we_o;
                end else if (r_addr !== dmem_addr_o || r_be !== dmem_be_o ||
                             r_wdata !== dmem_wdata_o || r_we !== dmem_we_o) begin
                    stable = 0;
                end
                if (c == v.delay + 1) begin
                    dmem_ack_i = 1'b1; dmem_rdata_i = v.rd;
                end
                if (v.poke && c == 2) begin
                    start_i = 1'b1; addr_i = 32'hFFFF_FFF0; ir_i = 32'h0000_2003;
                end
            end
            if (done_o) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
            dmem_ack_i = 1'b0; start_i = 1'b0; dmem_rdata_i = $urandom;
        end
        chk("done_cycle", done_cyc, v.e_done);
        chk("req_issued", {31'b0, req_seen}, {31'b0, v.e_req});
        if (v.e_req) begin
            chk("dmem_addr", r_addr, v.e_addr);
            chk("dmem_be", {28'b0, r_be}, {28'b0, v.e_be});
            chk("dmem_we", {31'b0, r_we}, {31'b0, v.e_we});
            if (v.e_we) chk("dmem_wdata", r_wdata, v.e_wdata);
            chk("req_stable", {31'b0, stable}, 32'h1);
        end
        chk("fault", {30'b0, fault_o}, {30'b0, v.e_fault});
        chk("mem_result", mem_o, v.e_mem);
        @(posedge clk); #1;
        chk("done_width", {31'b0, done_o}, 32'h0);
        chk("idle_after_done", {31'b0, busy_o}, 32'h0);
    endtask

    // Reference model: expected outcome of one operation from the ISA rules.
    function automatic vec_t model(input logic [31:0] ir, addr, sd, rd, input int delay,
                                   input bit poke, input logic [31:0] prev_mem);
        vec_t v;
        logic [2:0]  f3;
        bit          is_ld, is_st, legal;
        int          off, size;
        logic [31:0] sh;
        f3 = ir[14:12];
        is_ld = (ir[6:0] == 7'b0000011);
        is_st = (ir[6:0] == 7'b0100011);
        off = int'(addr[1:0]);
        size = 1 << f3[1:0];
        legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
        v = '{ir, addr, sd, rd, delay, poke, 1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 2'd0, prev_mem};
        if (!(is_ld || is_st)) begin
            v.e_fault = 2'd0;
        end else if (!legal) begin
            v.e_fault = 2'd2;
        end else if ((int'(addr[1:0]) % size) != 0) begin
            v.e_fault = 2'd1;
        end else begin
            v.e_req = 1;
            v.e_addr = addr & 32'hFFFF_FFFC;
            v.e_we = is_st;
            v.e_be = (size == 4 || is_ld) ? 4'hF : (size == 2 ? 4'(3 << off) : 4'(1 << off));
            v.e_wdata = (size == 1) ? {4{sd[7:0]}} : (size == 2) ? {2{sd[15:0]}} : sd;
            if (delay == 255) begin
                v.e_done = TMO + 1;
                v.e_fault = 2'd3;
            end else begin
                v.e_done = delay + 2;
                if (is_ld) begin
                    sh = rd >> (8 * off);
                    case (f3)
                        3'd0: v.e_mem = {{24{sh[7]}}, sh[7:0]};
                        3'd4: v.e_mem = {24'h0, sh[7:0]};
                        3'd1: v.e_mem = {{16{sh[15]}}, sh[15:0]};
                        3'd5: v.e_mem = {16'h0, sh[15:0]};
                        default: v.e_mem = rd;
                    endcase
                end
            end
        end
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        // ir, addr, sd, rd, delay, poke, e_done, e_req, e_addr, e_be, e_wdata, e_we, e_fault, e_mem
        vecs[0]  = '{32'h0000_0003, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 2, 1, 32'h1000, 4'hF, 32'h0, 1'b0, 2'd0, 32'hFFFF_FF80};
        vecs[1]  = '{32'h0000_4003, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 2, 1, 32'h1000, 4'hF, 32'h0, 1'b0, 2'd0, 32'h0000_0080};
        vecs[2]  = '{32'h0000_1023, 32'h2002, 32'hDEAD_BEEF, 32'h0, 3, 0, 5, 1, 32'h2000, 4'hC, 32'hBEEF_BEEF, 1'b1, 2'd0, 32'h0000_0080};
        vecs[3]  = '{32'h0000_2003, 32'h3001, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 2'd1, 32'h0000_0080};
        vecs[4]  = '{32'h0000_3003, 32'h3000, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 2'd2, 32'h0000_0080};
        vecs[5]  = '{32'h0000_2003, 32'h4000, 32'h0, 32'h0, 255, 0, 5, 1, 32'h4000, 4'hF, 32'h0, 1'b0, 2'd3, 32'h0000_0080};
        vecs[6]  = '{32'h0010_0093, 32'h1234, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 2'd0, 32'h0000_0080};
        vecs[7]  = '{32'h0000_1003, 32'h5002, 32'h0, 32'h8001_7FFF, 1, 0, 3, 1, 32'h5000, 4'hF, 32'h0, 1'b0, 2'd0, 32'hFFFF_8001};
        vecs[8]  = '{32'h0000_0023, 32'h6001, 32'h1234_5678, 32'h0, 0, 0, 2, 1, 32'h6000, 4'h2, 32'h7878_7878, 1'b1, 2'd0, 32'hFFFF_8001};
        vecs[9]  = '{32'h0000_2023, 32'h7000, 32'hCAFE_F00D, 32'h0, 2, 1, 4, 1, 32'h7000, 4'hF, 32'hCAFE_F00D, 1'b1, 2'd0, 32'hFFFF_8001};
        vecs[10] = '{32'h0000_4023, 32'h7000, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 2'd2, 32'hFFFF_8001};
        vecs[11] = '{32'h0000_5003, 32'h7001, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 2'd1, 32'hFFFF_8001};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, dmem_req_o}, 32'h0);
        chk("rst_we", {31'b0, dmem_we_o}, 32'h0);
        chk("rst_addr", dmem_addr_o, 32'h0);
        chk("rst_be", {28'b0, dmem_be_o}, 32'h0);
        chk("rst_wdata", dmem_wdata_o, 32'h0);
        chk("rst_mem", mem_o, 32'h0);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_fault", {30'b0, fault_o}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i]);
        end

        // Reset while a load request is outstanding; a late ack must be ignored.
        @(posedge clk); #1;
        ir_i = 32'h0000_2003; addr_i = 32'h8000; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("mid_req_high", {31'b0, dmem_req_o}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_req", {31'b0, dmem_req_o}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy_o}, 32'h0);
        chk("mid_rst_mem", mem_o, 32'h0);
        reset = 1'b1; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        chk("late_ack_done", {31'b0, done_o}, 32'h0);
        @(posedge clk); #1;
        chk("late_ack_done2", {31'b0, done_o}, 32'h0);
        chk("late_ack_mem", mem_o, 32'h0);
        model_mem = 32'h0;

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ir, addr;
            logic [6:0]  op;
            int          k, dly;
            vec_t        v;
            k = $urandom_range(0, 4);
            op = (k <= 1) ? 7'b0000011 : (k <= 3) ? 7'b0100011 : 7'b0010011;
            ir = ($urandom & 32'hFFFF_8F80) | ({29'b0, 3'($urandom_range(0, 7))} << 12) | {25'b0, op};
            addr = $urandom;
            dly = $urandom_range(0, 4);
            if (dly == 4) dly = 255;
            v = model(ir, addr, $urandom, $urandom, dly, 1'($urandom_range(0, 1)), model_mem);
            do_op(v);
            model_mem = v.e_mem;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the multi-cycle RV32I core. Sits between execute and write.
- Takes the effective address from execute and the instruction word, and drives a single-port data-memory request/acknowledge interface.
- Aligns store data into byte lanes and extracts/extends load data.
- Delivers the load result (mem_o) plus a one-cycle completion strobe that write uses to latch its result.

Parameters:
- TIMEOUT, 255, max cycles REQ waits for dmem_ack_i before aborting with a fault (1..255).

Ports:
- clk  input  1  core clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- start_i  input  1  one-cycle pulse: begin memory phase for current instruction
- ir_i  input  32  instruction word; [6:0] opcode, [14:12] funct3
- addr_i  input  32  effective address (rs1 + imm) from execute
- store_data_i  input  32  rs2 value for stores
- dmem_req_o  output  1  memory request valid
- dmem_we_o  output  1  1 = write, 0 = read
- dmem_addr_o  output  32  word address ({addr[31:2],2'b00})
- dmem_be_o  output  4  byte enables, bit n = byte lane n (little-endian)
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_rdata_i  input  32  read data, valid in the cycle dmem_ack_i = 1
- dmem_ack_i  input  1  memory completion
- mem_o  output  32  load result, held until the next successful load
- done_o  output  1  one-cycle completion strobe
- busy_o  output  1  1 in any state other than IDLE
- fault_o  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout

Behaviour:
- Reset (reset = 0 at a clock edge):
  - state = IDLE.
  - All outputs 0: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, mem_o, done_o, busy_o, fault_o.
  - Timeout counter = 0.
  - Reset mid-transaction aborts it: dmem_req_o falls at that edge, no done_o, and a late ack is ignored.
- Capture: ir_i, addr_i and store_data_i are registered when start_i is sampled in IDLE. Inputs may change afterwards.
- start_i outside IDLE is ignored.
- Classification on start (opcode 0000011 = load, 0100011 = store):
  - Legal funct3: load 000/001/010/100/101; store 000/001/010. Any other funct3 -> fault 10.
  - Halfword needs addr[0] = 0; word needs addr[1:0] = 0. Otherwise -> fault 01.
  - fault_o is updated at every start (00 on a clean op) and held until the next start.
- FSM:
  - IDLE: on start_i:
    - legal, aligned load/store -> REQ
    - faulting load/store -> DONE, no memory request
    - any other opcode -> DONE (pass-through, mem_o unchanged)
  - REQ: dmem_req_o = 1; dmem_addr_o/dmem_be_o/dmem_we_o/dmem_wdata_o stable.
    - dmem_ack_i = 1 -> DONE. If load, mem_o is loaded from dmem_rdata_i at that edge.
    - Counter reaches TIMEOUT with no ack -> DONE, fault 11, mem_o unchanged.
    - ack and timeout on the same cycle: ack wins.
  - DONE: done_o = 1 for exactly one cycle, dmem_req_o = 0 -> IDLE.
- Latency (start sampled at edge 0):
  - req high from cycle 1; ack sampled at edge k; done_o high in cycle k+1.
  - Zero-wait memory (ack in cycle 1): done_o in cycle 2.
  - Pass-through and fault cases: done_o in cycle 1.
  - Back-to-back: a new start_i is accepted in the cycle after done_o.
- Store lanes (off = addr[1:0]):
  - SB: be = 4'b0001 << off, wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << off, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
  - Loads: be = 4'b1111, we = 0.
- Load extract: sh = dmem_rdata_i >> (8*off).
  - LB sign-extends sh[7:0]; LBU zero-extends it.
  - LH sign-extends sh[15:0]; LHU zero-extends it.
  - LW takes the full word.
- dmem_ack_i outside REQ is ignored.

Test Plan:
- Reset with req high: reset = 0 while in REQ -> next cycle dmem_req_o = 0, busy_o = 0, mem_o = 0; ack pulsed afterwards -> no done_o.
- LB/LBU: addr 0x1003, rdata 0x80FF_1234, ack in cycle 1 -> dmem_addr_o 0x1000, be 4'b1111; done_o in cycle 2; mem_o 0xFFFF_FF80 (LB), 0x0000_0080 (LBU).
- SH: addr 0x2002, rs2 0xDEAD_BEEF -> be 4'b1100, wdata 0xBEEF_BEEF, we = 1; ack after 3 wait cycles -> done_o exactly 1 cycle after the ack edge, fault_o 00.
- Faults, no request issued: LW at 0x3001 -> fault_o 01, done_o in cycle 1; load with funct3 011 -> fault_o 10.
- Timeout, TIMEOUT = 4, ack never asserted -> done_o after 4 req cycles, fault_o 11, mem_o retains the previous load value.
- Pass-through and start-while-busy: ADDI pass-through -> done_o in cycle 1, dmem_req_o never set. start_i pulsed during REQ -> ignored; captured addr unchanged.
